mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter sharing the single-port 256 x 16 memory of the nano CPU system between port 0 (NanoCPU) and port 1 (loader/DMA/debug master). Grants at most one access per cycle, drives the memory's combinational-read / posedge-write interface, and returns read data registered one cycle later. A per-port lock gives a requester an exclusive window, for example for read-modify-write. A bounded lock counter guarantees the other port cannot starve.

## Interface
- AW, 8, address width (memory depth 2^AW)
- DW, 16, data width
- MAX_LOCK, 4, max consecutive exclusive cycles per lock window, including the grant cycle; legal range 2..255
- ck  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req0 / req1  in  1  access request, held until granted
- lock0 / lock1  in  1  request exclusive ownership after this grant
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  AW  access address
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  access performed this cycle (combinational)
- rvalid0 / rvalid1  out  1  registered read data valid (one-cycle pulse)
- rdata0 / rdata1  out  DW  registered read data
- mem_ce  out  1  memory enable (= gnt0 | gnt1)
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address; 0 when idle
- mem_wdata  out  DW  memory write data; 0 when idle
- mem_rdata  in  DW  combinational memory read data (mem[mem_addr])

## Operation
- State machine: IDLE, OWN0, OWN1. Registers: last (last granted port), lock_cnt (8 bit), force (the other port has priority in the next IDLE arbitration).
- IDLE:
  - Only one req → that port is granted.
  - Both req → winner chosen per Configuration. If force is set, the port that did not just expire wins regardless of mode, and force clears.
- Granted port x with lock_x=1 in IDLE → next state OWNx, lock_cnt=1. Otherwise next state stays IDLE.
- OWNx:
  - gnt_x = req_x. The other port's gnt is 0 even if it requests.
  - Each cycle, lock_cnt increments.
  - lock_x=0 → IDLE. The current cycle is still owned.
  - lock_cnt==MAX_LOCK-1 at the edge → IDLE, force=1.
  - OWNx with req_x=0 and lock_x=1 still holds ownership and consumes the count.
- Access: the granted port's addr/we/wdata are muxed to mem_*. mem_we = gnt & we. last updates on every grant.
- Read: if gnt_x & !we_x, rdata_x <= mem_rdata at the edge and rvalid_x=1 for the next cycle. Otherwise rvalid_x=0 and rdata_x holds.
- Writes never produce rvalid.

## Timing
- Grant latency 0: a req in IDLE with no competitor is granted in the same cycle.
- Write commits at the rising edge ending the grant cycle. A read of the same address in the next cycle returns the new data.
- Read latency 1: rvalid_x/rdata_x are valid in the cycle after gnt_x.
- Back-to-back grants to one port are allowed (one access per cycle).
- A port that is not granted must hold req/addr/we/wdata stable; the arbiter does not queue requests.
- Reset values: state IDLE, last=1, force=0, lock_cnt=0, gnt0/gnt1=0 while rst, rvalid0/rvalid1=0, rdata0/rdata1=0, mem_ce=0, mem_we=0, mem_addr=0, mem_wdata=0.
- rst mid-lock: state returns to IDLE and any pending rvalid is dropped. No memory write occurs in the reset cycle.
- Expiry with the other port idle: the owner may be re-granted in IDLE the next cycle and may re-lock. force clears on that grant.

## Configuration
- ARB_RR_EN defined: round-robin. On a both-request tie in IDLE, the port != last wins. After reset, port 0 wins the first tie.
- ARB_RR_EN undefined: fixed priority. Port 0 always wins ties, except the forced turn after lock expiry.
- Lock, the expiry counter, and force behave the same in both builds.

## Test plan
- Single read: memory[30]=0x0006, req0 read addr 30 → gnt0 in the same cycle, next cycle rvalid0=1, rdata0=0x0006. mem_we stays 0.
- Write then read: port 1 writes 0x000E to addr 20, then reads addr 20 the next cycle → rdata1=0x000E with rvalid1 one cycle after the read grant.
- Tie, ARB_RR_EN defined: req0 and req1 held continuously, no lock → grants alternate 0,1,0,1. Undefined → gnt0 every cycle, gnt1 never.
- Lock expiry, MAX_LOCK=4: port 0 holds req0 and lock0, port 1 holds req1 → gnt0 for 4 cycles, gnt1 in cycle 5 in both builds.
- Early unlock: port 0 locks, drops lock0 in its 2nd cycle while req1 is pending → gnt1 in the 3rd cycle. Port 1 is never granted during OWN0.
- Reset in OWN1 with a read pending → after rst, all outputs are 0 and state is IDLE. A following tie goes to port 0 with ARB_RR_EN defined.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the nano CPU 256x16 memory with lock windows.
// Define ARB_RR_EN for round-robin ties; fixed port-0 priority otherwise.
module mem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAX_LOCK = 4
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(MAX_LOCK - 1);

  state_t     r_state, w_nstate;
  logic       r_last, w_nlast;
  logic       r_force, w_nforce;
  logic [7:0] r_cnt, w_ncnt;
  logic       w_g0, w_g1, w_pick1;

  always_ff @(posedge ck) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_force <= 1'b0;
      r_cnt   <= 8'd0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      r_state <= w_nstate;
      r_last  <= w_nlast;
      r_force <= w_nforce;
      r_cnt   <= w_ncnt;
      rvalid0 <= w_g0 & ~we0;
      rvalid1 <= w_g1 & ~we1;
      if (w_g0 && !we0) rdata0 <= mem_rdata;
      if (w_g1 && !we1) rdata1 <= mem_rdata;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_nlast  = r_last;
    w_nforce = r_force;
    w_ncnt   = r_cnt;
    w_g0     = 1'b0;
    w_g1     = 1'b0;
    w_pick1  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req0 && req1) begin
          // a forced turn goes to the port that did not just own
          if (r_force) w_pick1 = ~r_last;
          else begin
`ifdef ARB_RR_EN
            w_pick1 = ~r_last;
`else
            w_pick1 = 1'b0;
`endif
          end
          w_g0 = ~w_pick1;
          w_g1 = w_pick1;
        end else begin
          w_g0 = req0;
          w_g1 = req1;
        end
        if (w_g0 || w_g1) begin
          w_nforce = 1'b0;
          w_nlast  = w_g1;
        end
        if (w_g0 && lock0) begin
          w_nstate = OWN0;
          w_ncnt   = 8'd1;
        end else if (w_g1 && lock1) begin
          w_nstate = OWN1;
          w_ncnt   = 8'd1;
        end
      end
      OWN0: begin
        w_g0   = req0;
        w_ncnt = r_cnt + 8'd1;
        if (req0) w_nlast = 1'b0;
        if (r_cnt == LAST_CNT) begin
          w_nstate = IDLE;
          w_nforce = 1'b1;
          w_ncnt   = 8'd0;
        end else if (!lock0) begin
          w_nstate = IDLE;
          w_ncnt   = 8'd0;
        end
      end
      OWN1: begin
        w_g1   = req1;
        w_ncnt = r_cnt + 8'd1;
        if (req1) w_nlast = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_nstate = IDLE;
          w_nforce = 1'b1;
          w_ncnt   = 8'd0;
        end else if (!lock1) begin
          w_nstate = IDLE;
          w_ncnt   = 8'd0;
        end
      end
      default: begin
        w_nstate = IDLE;
        w_ncnt   = 8'd0;
      end
    endcase
  end

  assign gnt0      = w_g0 & ~rst;
  assign gnt1      = w_g1 & ~rst;
  assign mem_ce    = gnt0 | gnt1;
  assign mem_we    = (gnt0 & we0) | (gnt1 & we1);
  assign mem_addr  = gnt0 ? addr0 : (gnt1 ? addr1 : '0);
  assign mem_wdata = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256x16 memory.
// Expectations follow ARB_RR_EN when the bench is built with it.
module tb_mem_arbiter;

  logic        ck = 1'b0;
  logic        rst;
  logic        req0, req1, lock0, lock1, we0, we1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic        mem_ce, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  logic [15:0] mem [256];
  int n_run = 0;
  int n_fail = 0;

  mem_arbiter #(.AW(8), .DW(16), .MAX_LOCK(4)) dut (
    .ck(ck), .rst(rst),
    .req0(req0), .req1(req1),
    .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_ce(mem_ce), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 ck = ~ck;

  always @(posedge ck) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic idle_in();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    we0 = 0; we1 = 0;
  endtask

  logic rr;

  initial begin
`ifdef ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    rst = 1; idle_in();
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    tick(); tick();
    req0 = 1; we0 = 1; addr0 = 8'h55; wdata0 = 16'hBEEF;
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_ce", mem_ce, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rv0", rvalid0, 0);
    chk("rst_rd1", rdata1, 0);

    // port 1 writes 6 to addr 30
    tick(); rst = 0; idle_in();
    req1 = 1; we1 = 1; addr1 = 30; wdata1 = 16'h0006;
    #1;
    chk("w30_gnt1", gnt1, 1);
    chk("w30_gnt0", gnt0, 0);
    chk("w30_we", mem_we, 1);
    chk("w30_addr", mem_addr, 30);
    chk("w30_wd", mem_wdata, 16'h0006);

    tick(); idle_in();
    req0 = 1; addr0 = 30;
    #1;
    chk("r30_gnt0", gnt0, 1);
    chk("r30_we", mem_we, 0);
    chk("w30_norv", rvalid1, 0);

    tick(); idle_in();
    #1;
    chk("r30_rv", rvalid0, 1);
    chk("r30_rd", rdata0, 16'h0006);
    chk("idle_ce", mem_ce, 0);
    chk("idle_addr", mem_addr, 0);
    chk("idle_wd", mem_wdata, 0);

    // write 0xE to addr 20 then read it back
    tick(); idle_in();
    req1 = 1; we1 = 1; addr1 = 20; wdata1 = 16'h000E;
    #1;
    chk("w20_gnt1", gnt1, 1);
    chk("r30_rv_pulse", rvalid0, 0);
    tick();
    we1 = 0;
    #1;
    chk("r20_gnt1", gnt1, 1);
    chk("r20_addr", mem_addr, 20);
    chk("w20_norv", rvalid1, 0);
    tick(); idle_in();
    #1;
    chk("r20_rv", rvalid1, 1);
    chk("r20_rd", rdata1, 16'h000E);

    // tie, no lock; last=1 here
    tick(); idle_in();
    req0 = 1; req1 = 1; addr0 = 0; addr1 = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("tie%0d_g0", i), gnt0, rr ? ((i % 2) == 0) : 1);
      chk($sformatf("tie%0d_g1", i), gnt1, rr ? ((i % 2) == 1) : 0);
      tick();
    end
    idle_in();

    // lock expiry, MAX_LOCK=4
    tick();
    req0 = 1; lock0 = 1; req1 = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("exp%0d_g0", i), gnt0, i < 4);
      chk($sformatf("exp%0d_g1", i), gnt1, i == 4);
      tick();
    end
    idle_in();

    // early unlock
    tick();
    req0 = 1; lock0 = 1; req1 = 1;
    #1;
    chk("eu1_g0", gnt0, 1);
    tick();
    lock0 = 0;
    #1;
    chk("eu2_g0", gnt0, 1);
    chk("eu2_g1", gnt1, 0);
    tick();
    req0 = 0;
    #1;
    chk("eu3_g1", gnt1, 1);
    tick(); idle_in();

    // reset while port 1 owns with a read in flight
    tick();
    req1 = 1; lock1 = 1; addr1 = 20;
    #1;
    chk("own1_g1", gnt1, 1);
    tick();
    #1;
    chk("own1b_g1", gnt1, 1);
    chk("own1b_g0_req", gnt0, 0);
    tick();
    rst = 1;
    #1;
    chk("rstown_g1", gnt1, 0);
    chk("rstown_ce", mem_ce, 0);
    tick();
    rst = 0; idle_in();
    #1;
    chk("post_rv1", rvalid1, 0);
    chk("post_rd1", rdata1, 0);
    chk("post_rd0", rdata0, 0);
    chk("post_g1", gnt1, 0);
    tick();
    req0 = 1; req1 = 1;
    #1;
    chk("post_tie_g0", gnt0, 1);
    chk("post_tie_g1", gnt1, 0);
    tick();
    #1;
    chk("post_tie2_g1", gnt1, rr);
    tick(); idle_in();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
